// File: rtl/muladd_pkg.sv
// Shared constants, read-FSM state type and the word-to-element address
// mapping for the mul-add result collector.
package muladd_pkg;

  localparam int ELEM_W          = 16;
  localparam int DIM             = 16;
  localparam int WORDS_PER_FRAME = 128;
  localparam int ELEMS_PER_FRAME = 256;
  localparam int IDX_W           = 8;
  localparam int WCNT_W          = 7;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } rd_state_e;

  // Word n carries column n[6:3] of row pair n[2:0]; hi selects the odd row.
  function automatic logic [IDX_W-1:0] word_addr(input logic [WCNT_W-1:0] n, input logic hi);
    return {n[2:0], hi, n[6:3]};
  endfunction

endpackage

// File: rtl/muladd_result_collector_if.sv
// Result-word input stream and element output stream of the collector.
interface muladd_result_collector_if #(
  parameter int ELEM_W = 16
);
  logic                  result_valid_i;
  logic [2*ELEM_W-1:0]   result_payload_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [ELEM_W-1:0]     out_data_o;
  logic [7:0]            out_idx_o;
  logic                  out_last_o;

  modport master (
    output result_valid_i, result_payload_i, out_ready_i,
    input  out_valid_o, out_data_o, out_idx_o, out_last_o
  );

  modport slave (
    input  result_valid_i, result_payload_i, out_ready_i,
    output out_valid_o, out_data_o, out_idx_o, out_last_o
  );
endinterface

// File: rtl/muladd_result_bank.sv
// One frame buffer: two elements written per cycle, one element read
// asynchronously. Contents are not reset.
module muladd_result_bank #(
  parameter int ELEM_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr_lo,
  input  logic [AW-1:0]     waddr_hi,
  input  logic [ELEM_W-1:0] wdata_lo,
  input  logic [ELEM_W-1:0] wdata_hi,
  input  logic [AW-1:0]     raddr,
  output logic [ELEM_W-1:0] rdata
);

  logic [ELEM_W-1:0] mem_r [DEPTH];

  // Dual-element write; the two addresses always differ in the row bit
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr_lo] <= wdata_lo;
      mem_r[waddr_hi] <= wdata_hi;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/muladd_result_collector.sv
// Ping-pong frame collector: column-ordered result words fill one bank while
// the other drains as a row-major element stream.
module muladd_result_collector #(
  parameter int ELEM_W = 16,
  parameter int DIM    = 16
) (
  input  logic                     clk_data,
  input  logic                     rst_n,
  input  logic                     clear_i,
  muladd_result_collector_if.slave bus,
  output logic                     overflow_o,
  output logic [7:0]               frame_cnt_o
);
  import muladd_pkg::*;

  localparam int DEPTH = DIM * DIM;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_FRAME - 1);

  rd_state_e          state_r, state_next_s;
  logic [WCNT_W-1:0]  wr_cnt_r;
  logic               wr_sel_r, rd_sel_r, rd_sel_next_s;
  logic [1:0]         full_r, full_next_s;
  logic [IDX_W-1:0]   rd_idx_r, rd_idx_next_s;
  logic               accept_s, drop_s, wr_last_s, rd_done_s;
  logic               overflow_r, out_valid_r, out_last_r;
  logic [7:0]         frame_cnt_r;
  logic [IDX_W-1:0]   out_idx_r;
  logic [ELEM_W-1:0]  out_data_r, bank0_rdata_s, bank1_rdata_s, rd_data_s;

  // Accept or drop the incoming result word
  always_comb begin
    accept_s  = 1'b0;
    drop_s    = 1'b0;
    wr_last_s = 1'b0;
    if (bus.result_valid_i && !clear_i) begin
      if (full_r[wr_sel_r]) begin
        drop_s = 1'b1;
      end else begin
        accept_s  = 1'b1;
        wr_last_s = (wr_cnt_r == LAST_WORD);
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Freeing the read bank and filling the write bank may land on one edge
  always_comb begin
    full_next_s[0] = (full_r[0] & ~(rd_done_s & ~rd_sel_r)) | (wr_last_s & ~wr_sel_r);
    full_next_s[1] = (full_r[1] & ~(rd_done_s &  rd_sel_r)) | (wr_last_s &  wr_sel_r);
  end

  // Read FSM next state and read pointer
  always_comb begin
    state_next_s  = state_r;
    rd_idx_next_s = rd_idx_r;
    rd_sel_next_s = rd_sel_r;
    rd_done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (full_r[rd_sel_r]) state_next_s = ST_DRAIN;
        else                  state_next_s = ST_IDLE;
      end
      ST_DRAIN: begin
        if (bus.out_ready_i) begin
          if (rd_idx_r == LAST_IDX) begin
            rd_done_s     = 1'b1;
            state_next_s  = ST_IDLE;
            rd_idx_next_s = {IDX_W{1'b0}};
            rd_sel_next_s = ~rd_sel_r;
          end else begin
            rd_idx_next_s = rd_idx_r + 8'd1;
          end
        end else begin
          rd_idx_next_s = rd_idx_r;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Banks are read at the next pointer so the output register holds the current element
  assign rd_data_s = rd_sel_next_s ? bank1_rdata_s : bank0_rdata_s;

  muladd_result_bank #(.ELEM_W(ELEM_W), .DEPTH(DEPTH)) u_bank0 (
    .clk      (clk_data),
    .we       (accept_s && !wr_sel_r),
    .waddr_lo (word_addr(wr_cnt_r, 1'b0)),
    .waddr_hi (word_addr(wr_cnt_r, 1'b1)),
    .wdata_lo (bus.result_payload_i[ELEM_W-1:0]),
    .wdata_hi (bus.result_payload_i[2*ELEM_W-1:ELEM_W]),
    .raddr    (rd_idx_next_s),
    .rdata    (bank0_rdata_s)
  );

  muladd_result_bank #(.ELEM_W(ELEM_W), .DEPTH(DEPTH)) u_bank1 (
    .clk      (clk_data),
    .we       (accept_s && wr_sel_r),
    .waddr_lo (word_addr(wr_cnt_r, 1'b0)),
    .waddr_hi (word_addr(wr_cnt_r, 1'b1)),
    .wdata_lo (bus.result_payload_i[ELEM_W-1:0]),
    .wdata_hi (bus.result_payload_i[2*ELEM_W-1:ELEM_W]),
    .raddr    (rd_idx_next_s),
    .rdata    (bank1_rdata_s)
  );

  // Write side state: counter, bank select, full flags, drop flag, frame count
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_r    <= {WCNT_W{1'b0}};
      wr_sel_r    <= 1'b0;
      full_r      <= 2'b00;
      overflow_r  <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else if (clear_i) begin
      wr_cnt_r    <= {WCNT_W{1'b0}};
      wr_sel_r    <= 1'b0;
      full_r      <= 2'b00;
      overflow_r  <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else begin
      full_r <= full_next_s;
      if (accept_s) begin
        if (wr_last_s) begin
          wr_cnt_r <= {WCNT_W{1'b0}};
          wr_sel_r <= ~wr_sel_r;
        end else begin
          wr_cnt_r <= wr_cnt_r + 7'd1;
        end
      end
      if (drop_s)    overflow_r  <= 1'b1;
      if (rd_done_s) frame_cnt_r <= frame_cnt_r + 8'd1;
    end
  end

  // Read side state and registered output stream
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rd_idx_r    <= {IDX_W{1'b0}};
      rd_sel_r    <= 1'b0;
      out_valid_r <= 1'b0;
      out_idx_r   <= {IDX_W{1'b0}};
      out_last_r  <= 1'b0;
      out_data_r  <= {ELEM_W{1'b0}};
    end else if (clear_i) begin
      state_r     <= ST_IDLE;
      rd_idx_r    <= {IDX_W{1'b0}};
      rd_sel_r    <= 1'b0;
      out_valid_r <= 1'b0;
      out_idx_r   <= {IDX_W{1'b0}};
      out_last_r  <= 1'b0;
      out_data_r  <= {ELEM_W{1'b0}};
    end else begin
      state_r     <= state_next_s;
      rd_idx_r    <= rd_idx_next_s;
      rd_sel_r    <= rd_sel_next_s;
      out_valid_r <= (state_next_s == ST_DRAIN);
      if (state_next_s == ST_DRAIN) begin
        out_idx_r  <= rd_idx_next_s;
        out_last_r <= (rd_idx_next_s == LAST_IDX);
        out_data_r <= rd_data_s;
      end else begin
        out_idx_r  <= {IDX_W{1'b0}};
        out_last_r <= 1'b0;
        out_data_r <= {ELEM_W{1'b0}};
      end
    end
  end

  assign bus.out_valid_o = out_valid_r;
  assign bus.out_idx_o   = out_idx_r;
  assign bus.out_last_o  = out_last_r;
  assign bus.out_data_o  = out_data_r;
  assign overflow_o      = overflow_r;
  assign frame_cnt_o     = frame_cnt_r;

endmodule

// File: tb/tb_muladd_result_collector.sv
// Bench for muladd_result_collector: frame table plus corner-case sequences,
// every output element checked against a scoreboard queue.
module tb_muladd_result_collector;

  logic       clk_data;
  logic       rst_n;
  logic       clear_i;
  logic       overflow_o;
  logic [7:0] frame_cnt_o;

  muladd_result_collector_if #(.ELEM_W(16)) bus ();

  muladd_result_collector #(.ELEM_W(16), .DIM(16)) dut (
    .clk_data    (clk_data),
    .rst_n       (rst_n),
    .clear_i     (clear_i),
    .bus         (bus),
    .overflow_o  (overflow_o),
    .frame_cnt_o (frame_cnt_o)
  );

  int errors = 0;
  int checks = 0;
  int frames_seen = 0;
  int vcycles = 0;
  int last_cycles = 0;
  int ready_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 never
  logic [24:0] sb [$]; // {idx, data, last}

  typedef struct {
    logic [15:0] base;
    int          mode;
    int          exp_cnt;
    int          min_cyc;
    int          max_cyc;
  } vec_t;
  vec_t vecs [4];

  initial begin
    clk_data = 1'b0;
    forever #5 clk_data = ~clk_data;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] word_payload(input logic [15:0] base, input int n);
    int k = n / 8;
    int i = n % 8;
    int a = 2 * i * 16 + k;
    return {16'(base + a + 256), 16'(base + a)};
  endfunction

  // Element at row-major idx: even rows carry the low half, odd rows the high half
  function automatic logic [15:0] exp_elem(input logic [15:0] base, input int idx);
    int row = idx / 16;
    int col = idx % 16;
    if (row % 2 == 0) return 16'(base + idx);
    else              return 16'(base + (row - 1) * 16 + col + 256);
  endfunction

  task automatic push_frame(input logic [15:0] base);
    for (int x = 0; x < 256; x++) sb.push_back({8'(x), exp_elem(base, x), x == 255});
  endtask

  task automatic send_words(input logic [15:0] base, input int first, input int count);
    for (int n = first; n < first + count; n++) begin
      bus.result_valid_i   = 1'b1;
      bus.result_payload_i = word_payload(base, n);
      @(posedge clk_data); #1;
    end
    bus.result_valid_i = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk_data);
      n++;
    end
    @(posedge clk_data); #1;
    if (frames_seen < target) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, frames drained %0d expected %0d", name, frames_seen, target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, bus.out_valid_o, 0);
    check({tag, "_idx"}, bus.out_idx_o, 0);
    check({tag, "_last"}, bus.out_last_o, 0);
    check({tag, "_data"}, bus.out_data_o, 0);
    check({tag, "_overflow"}, overflow_o, 0);
    check({tag, "_frame_cnt"}, frame_cnt_o, 0);
  endtask

  // Consumer ready pattern
  initial begin
    bus.out_ready_i = 1'b0;
    forever begin
      @(posedge clk_data); #1;
      case (ready_mode)
        0:       bus.out_ready_i = 1'b1;
        1:       bus.out_ready_i = ~bus.out_ready_i;
        2:       bus.out_ready_i = 1'($urandom_range(0, 1));
        default: bus.out_ready_i = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard compare on handshake, stability while stalled
  initial begin
    logic        prev_stall;
    logic [25:0] prev_vec, cur_vec;
    logic [24:0] exp;
    prev_stall = 1'b0;
    prev_vec   = '0;
    forever begin
      @(negedge clk_data);
      if (!rst_n) begin
        prev_stall = 1'b0;
        vcycles    = 0;
      end else begin
        cur_vec = {bus.out_valid_o, bus.out_last_o, bus.out_idx_o, bus.out_data_o};
        if (prev_stall) check("stall_hold", 32'(cur_vec), 32'(prev_vec));
        if (bus.out_valid_o) vcycles++;
        if (bus.out_valid_o && bus.out_ready_i) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_elem: got idx %0d data 0x%0h, expected none",
                     bus.out_idx_o, bus.out_data_o);
          end else begin
            exp = sb.pop_front();
            check($sformatf("elem_idx%0d", exp[24:17]),
                  {7'd0, bus.out_idx_o, bus.out_data_o, bus.out_last_o}, {7'd0, exp});
          end
          if (bus.out_last_o) begin
            frames_seen++;
            last_cycles = vcycles;
            vcycles     = 0;
          end
        end
        prev_stall = bus.out_valid_o && !bus.out_ready_i;
        prev_vec   = cur_vec;
      end
    end
  end

  initial begin
    int fs;
    int sent;
    int n;

    vecs[0] = '{16'h0000, 0, 1, 256, 256};
    vecs[1] = '{16'h1000, 1, 2, 511, 512};
    vecs[2] = '{16'h2345, 2, 3, 256, 2000};
    vecs[3] = '{16'hF0F0, 0, 4, 256, 256};

    rst_n                = 1'b0;
    clear_i              = 1'b0;
    bus.result_valid_i   = 1'b0;
    bus.result_payload_i = 32'd0;
    repeat (3) @(posedge clk_data);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_data) rst_n = 1'b1;
    @(posedge clk_data); #1;

    // Table of single frames under different consumer patterns
    for (int v = 0; v < 4; v++) begin
      ready_mode = vecs[v].mode;
      fs = frames_seen;
      push_frame(vecs[v].base);
      send_words(vecs[v].base, 0, 128);
      wait_frames(fs + 1, 3000, $sformatf("vec%0d_drain", v));
      check($sformatf("vec%0d_frame_cnt", v), frame_cnt_o, vecs[v].exp_cnt);
      checks++;
      if (last_cycles < vecs[v].min_cyc || last_cycles > vecs[v].max_cyc) begin
        errors++;
        $display("FAIL vec%0d_drain_cycles: got %0d expected %0d..%0d",
                 v, last_cycles, vecs[v].min_cyc, vecs[v].max_cyc);
      end
      check($sformatf("vec%0d_sb_empty", v), sb.size(), 0);
      check($sformatf("vec%0d_overflow", v), overflow_o, 0);
    end

    // Both banks full with consumer stalled: third frame dropped
    ready_mode = 3;
    repeat (2) @(posedge clk_data);
    #1;
    fs = frames_seen;
    push_frame(16'h4000);
    push_frame(16'h5000);
    send_words(16'h4000, 0, 128);
    send_words(16'h5000, 0, 128);
    check("ovf_before_drop", overflow_o, 0);
    send_words(16'h6000, 0, 1);
    check("ovf_after_drop", overflow_o, 1);
    check("ovf_stalled_valid", bus.out_valid_o, 1);
    check("ovf_stalled_idx", bus.out_idx_o, 0);
    send_words(16'h6000, 1, 127);
    ready_mode = 0;
    wait_frames(fs + 2, 2000, "ovf_drain");
    check("ovf_frame_cnt", frame_cnt_o, 6);
    check("ovf_sb_empty", sb.size(), 0);
    check("ovf_sticky", overflow_o, 1);

    // Clear during a partial frame, dominating a valid word
    send_words(16'h7000, 0, 60);
    bus.result_valid_i   = 1'b1;
    bus.result_payload_i = word_payload(16'h7000, 60);
    clear_i              = 1'b1;
    @(posedge clk_data); #1;
    clear_i            = 1'b0;
    bus.result_valid_i = 1'b0;
    check("clr_overflow", overflow_o, 0);
    check("clr_frame_cnt", frame_cnt_o, 0);
    check("clr_valid", bus.out_valid_o, 0);
    fs = frames_seen;
    push_frame(16'h7100);
    send_words(16'h7100, 0, 128);
    wait_frames(fs + 1, 1000, "clr_drain");
    check("clr_frame_cnt_after", frame_cnt_o, 1);
    check("clr_sb_empty", sb.size(), 0);

    // Second frame completes on the edge of the first frame's final handshake
    fs = frames_seen;
    push_frame(16'h8000);
    push_frame(16'h9000);
    send_words(16'h8000, 0, 128);
    repeat (129) begin
      @(posedge clk_data); #1;
    end
    send_words(16'h9000, 0, 127);
    bus.result_valid_i   = 1'b1;
    bus.result_payload_i = word_payload(16'h9000, 127);
    check("pp_coincide_valid_last", {bus.out_valid_o, bus.out_last_o}, 2'b11);
    @(posedge clk_data); #1;
    bus.result_valid_i = 1'b0;
    check("pp_idle_gap", bus.out_valid_o, 0);
    check("pp_no_drop", overflow_o, 0);
    @(posedge clk_data); #1;
    check("pp_restart_valid", bus.out_valid_o, 1);
    check("pp_restart_idx", bus.out_idx_o, 0);
    wait_frames(fs + 2, 1000, "pp_drain");
    check("pp_frame_cnt", frame_cnt_o, 3);
    check("pp_sb_empty", sb.size(), 0);

    // Asynchronous reset mid-drain, then mid-fill
    push_frame(16'hA000);
    send_words(16'hA000, 0, 128);
    n = 0;
    while (!(bus.out_valid_o && bus.out_idx_o == 8'd100) && n < 1000) begin
      @(negedge clk_data);
      n++;
    end
    check("rst_reached_idx100", bus.out_idx_o, 100);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_drain");
    sb.delete();
    @(negedge clk_data) rst_n = 1'b1;
    @(posedge clk_data); #1;
    send_words(16'hB000, 0, 60);
    bus.result_valid_i   = 1'b1;
    bus.result_payload_i = word_payload(16'hB000, 60);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_fill");
    bus.result_valid_i = 1'b0;
    @(negedge clk_data) rst_n = 1'b1;
    @(posedge clk_data); #1;
    fs = frames_seen;
    push_frame(16'hC000);
    send_words(16'hC000, 0, 128);
    wait_frames(fs + 1, 1000, "rst_recover_drain");
    check("rst_recover_frame_cnt", frame_cnt_o, 1);
    check("rst_recover_sb_empty", sb.size(), 0);

    // 256 streamed frames: frame counter wraps
    @(negedge clk_data) rst_n = 1'b0;
    @(negedge clk_data) rst_n = 1'b1;
    @(posedge clk_data); #1;
    fs   = frames_seen;
    sent = 0;
    for (int j = 0; j < 256; j++) begin
      n = 0;
      while ((sent - (frames_seen - fs)) >= 2 && n < 1000) begin
        @(posedge clk_data); #1;
        n++;
      end
      if (n >= 1000) begin
        checks++;
        errors++;
        $display("FAIL wrap_gate: frame %0d waited %0d cycles for a free bank", j, n);
      end
      push_frame(16'(j * 7));
      send_words(16'(j * 7), 0, 128);
      sent++;
    end
    wait_frames(fs + 255, 2000, "wrap_255");
    check("wrap_frame_cnt_255", frame_cnt_o, 255);
    wait_frames(fs + 256, 1000, "wrap_256");
    check("wrap_frame_cnt_0", frame_cnt_o, 0);
    check("wrap_overflow", overflow_o, 0);
    check("wrap_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muladd_result_collector.md
MULADD_RESULT_COLLECTOR -- requirements
Module: muladd_result_collector

Interface
REQ-001 SHALL have these parameters (name, default, meaning): ELEM_W, 16, element width; DIM, 16, matrix dimension (DIM x DIM output frame).
REQ-002 SHALL have these ports (name, direction, width, meaning); clk_data, in, 1, sole clock, all logic rising-edge.
REQ-003 rst_n, in, 1, asynchronous active-low reset.
REQ-004 clear_i, in, 1, synchronous flush of all state.
REQ-005 result_valid_i, in, 1, one result word present this cycle.
REQ-006 result_payload_i, in, 32, [15:0] = element row 2i, col k; [31:16] = element row 2i+1, col k.
REQ-007 out_valid_o, out, 1, output element valid.
REQ-008 out_ready_i, in, 1, consumer accepts element.
REQ-009 out_data_o, out, 16, output element.
REQ-010 out_idx_o, out, 8, row*16+col of out_data_o.
REQ-011 out_last_o, out, 1, high with idx 255.
REQ-012 overflow_o, out, 1, sticky: word dropped.
REQ-013 frame_cnt_o, out, 8, frames fully drained, wraps 255->0.

Function
REQ-014 SHALL hold two 256x16 banks (ping-pong); one write-selected, one read-selected, each with a full flag.
REQ-015 Write order: word n (0..127) of a frame SHALL go to col k=n[6:3], pair i=n[2:0]; low half to address (2i)*16+k, high half to (2i+1)*16+k.
REQ-016 Word SHALL be accepted only when result_valid_i=1 and write bank not full; accepted word advances write counter.
REQ-017 On accepting word 127: write bank full flag SHALL set, write select toggles, write counter returns to 0, same edge.
REQ-018 Word arriving while write bank full SHALL be dropped, counter unchanged, overflow_o set until reset/clear_i.
REQ-019 Read FSM states IDLE and DRAIN; IDLE->DRAIN when read bank full; DRAIN->IDLE after handshake at idx 255.
REQ-020 out_valid_o SHALL be 1 exactly in DRAIN; first out_valid_o one cycle after the edge that set the full flag.
REQ-021 Readout SHALL be row-major, idx 0..255, one element per out_valid_o & out_ready_i cycle.
REQ-022 With out_valid_o=1 and out_ready_i=0, out_data_o/out_idx_o/out_last_o SHALL hold stable.
REQ-023 On final handshake: read bank full flag clears, read select toggles, read index returns to 0, frame_cnt_o increments.
REQ-024 Bank freed and other bank filled on the same edge SHALL both take effect; no word lost, no drop flagged.
REQ-025 Frame completing while other bank draining SHALL wait; DRAIN of it starts cycle after current drain's last handshake plus one (IDLE visited one cycle).
REQ-026 clear_i SHALL dominate result_valid_i and handshakes in its cycle; banks' contents need not be cleared.

Reset
REQ-027 On rst_n=0 (any time, mid-frame or mid-drain): counters 0, full flags 0, selects to bank 0, FSM IDLE, out_valid_o 0, out_idx_o 0, out_last_o 0, out_data_o 0, overflow_o 0, frame_cnt_o 0.
REQ-028 clear_i=1 SHALL produce the same state on the next edge.
REQ-029 Partial frame at reset/clear SHALL be discarded, never output.

Structure
REQ-030 Package muladd_pkg SHALL hold ELEM_W, DIM, WORDS_PER_FRAME=128, ELEMS_PER_FRAME=256, and read FSM state enum.
REQ-031 Sub-module muladd_result_bank (256x16, dual-element write port, single read port) SHALL be instanced twice.

Verification
REQ-032 Reset, 128 words with payload {16'(2i*16+k+256),16'(2i*16+k)} style unique values, out_ready_i=1 -> 256 elements idx 0..255 in order, data matches address mapping, last only at 255, frame_cnt_o=1.
REQ-033 Same frame, out_ready_i toggling 1/0 each cycle -> identical sequence, outputs stable while stalled, 512 cycles drain.
REQ-034 Three back-to-back frames, out_ready_i=0 -> frames 1,2 stored, word 0 of frame 3 dropped, overflow_o=1; release ready -> frames 1 then 2 drained intact.
REQ-035 Frame 2's word 127 accepted on same edge as frame 1's idx 255 handshake -> no drop, frame 2 drains starting after one IDLE cycle.
REQ-036 rst_n low asynchronously at drain idx 100 and again at fill word 60 -> outputs to reset values immediately; next full frame read correctly, frame_cnt_o counts from 0.
REQ-037 255 full frames plus one more -> frame_cnt_o wraps to 0.
